// File: rtl/vga_dither_pkg.sv
// Shared types and constants for the VGA dither quantiser: mode encoding,
// the 4x4 ordered-dither matrix and the idle level of the active-low syncs.
package vga_dither_pkg;

  typedef enum logic [1:0] {
    MODE_ROUND     = 2'd0,
    MODE_TEMPORAL  = 2'd1,
    MODE_BAYER     = 2'd2,
    MODE_BAYER_ROT = 2'd3
  } mode_e;

  // Indexed [y][x]
  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

  localparam logic SYNC_IDLE = 1'b1;

endpackage

// File: rtl/vga_dither_chan.sv
// One colour channel: depth expansion into stage p0, threshold quantise
// with saturation into stage p1.
module vga_dither_chan
  import vga_dither_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2,
  parameter int DEP_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  c,
  input  logic [DEP_W-1:0] depth,
  input  logic [IN_W-1:0]  thr,
  output logic [OUT_W-1:0] q
);

  localparam int PW = IN_W + OUT_W + 1;
  localparam logic [OUT_W:0] LMAX = {1'b0, {OUT_W{1'b1}}};

  logic [IN_W-1:0]  t_p0;
  logic [IN_W-1:0]  thr_p0;
  logic [OUT_W-1:0] q_p1;

  // Keep the top depth+1 bits and refill the LSBs by repeating them from the MSB.
  function automatic logic [IN_W-1:0] expand(input logic [IN_W-1:0] v,
                                             input logic [DEP_W-1:0] dep);
    int k;
    logic [IN_W-1:0] t;
    k = (int'(dep) > IN_W - 1) ? IN_W : int'(dep) + 1;
    t = '0;
    for (int i = 0; i < IN_W; i++) t[IN_W-1-i] = v[IN_W-1-(i % k)];
    return t;
  endfunction

  function automatic logic [OUT_W-1:0] quantise(input logic [IN_W-1:0] t,
                                                input logic [IN_W-1:0] th);
    logic [PW-1:0]  p;
    logic [OUT_W:0] lvl;
    p   = PW'(t) * PW'(LMAX) + PW'(th);
    lvl = p[PW-1:IN_W];
    return (lvl > LMAX) ? LMAX[OUT_W-1:0] : lvl[OUT_W-1:0];
  endfunction

  // Stage p0: expanded target and threshold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_p0   <= '0;
      thr_p0 <= '0;
    end else begin
      t_p0   <= expand(c, depth);
      thr_p0 <= thr;
    end
  end

  // Stage p1: quantised level
  always_ff @(posedge clk) begin
    if (!rst_n) q_p1 <= '0;
    else        q_p1 <= quantise(t_p0, thr_p0);
  end

  assign q = q_p1;

endmodule

// File: rtl/vga_dither_quantizer.sv
// VGA colour quantiser with round, temporal and ordered dither; two-clock latency.
// Ordered (Bayer) modes are built only when VGA_DITHER_BAYER_EN is defined.
module vga_dither_quantizer
  import vga_dither_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2,
  parameter int STEP  = 149
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_W-1:0]          r,
  input  logic [IN_W-1:0]          g,
  input  logic [IN_W-1:0]          b,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [$clog2(IN_W)-1:0]  depth,
  input  logic [1:0]               mode,
  output logic [OUT_W-1:0]         red,
  output logic [OUT_W-1:0]         green,
  output logic [OUT_W-1:0]         blue,
  output logic                     hsync_out,
  output logic                     vsync_out
);

  localparam int DEP_W = $clog2(IN_W);
  localparam logic [IN_W-1:0] HALF   = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] STEP_V = IN_W'(STEP);

  logic [10:0]      x;
  logic [10:0]      y;
  logic [IN_W-1:0]  acc;
  logic [IN_W-1:0]  thr;
  logic [DEP_W-1:0] dep_s;
  mode_e            mode_s;
  logic             hs_prev;
  logic             hs_p0, hs_p1;
  logic             vs_p0, vs_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      acc     <= '0;
      dep_s   <= DEP_W'(IN_W - 1);
      mode_s  <= MODE_ROUND;
      hs_prev <= SYNC_IDLE;
    end else begin
      x <= (hsync == SYNC_IDLE) ? x + 11'd1 : '0;
      if (vsync != SYNC_IDLE)
        y <= '0;
      else if (hs_prev == SYNC_IDLE && hsync != SYNC_IDLE)
        y <= y + 11'd1;
      acc <= (vsync == SYNC_IDLE) ? acc + STEP_V : '0;
      // Configuration only moves during vertical sync
      if (vsync != SYNC_IDLE) begin
        dep_s  <= depth;
        mode_s <= mode_e'(mode);
      end
      hs_prev <= hsync;
    end
  end

`ifdef VGA_DITHER_BAYER_EN
  logic [1:0] f;
  logic       vs_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f       <= '0;
      vs_prev <= SYNC_IDLE;
    end else begin
      if (vs_prev == SYNC_IDLE && vsync != SYNC_IDLE) f <= f + 2'd1;
      vs_prev <= vsync;
    end
  end

  // Matrix entry scaled to the top nibble, centred with a half-step offset.
  function automatic logic [IN_W-1:0] bayer_thr(input logic [1:0] xi,
                                                 input logic [1:0] yi);
    logic [IN_W+3:0] v;
    v = {BAYER[yi][xi], 1'b1, {(IN_W-1){1'b0}}};
    return v[IN_W+3:4];
  endfunction
`endif

  always_comb begin
    thr = acc;
    case (mode_s)
      MODE_ROUND:     thr = HALF;
`ifdef VGA_DITHER_BAYER_EN
      MODE_BAYER:     thr = bayer_thr(x[1:0], y[1:0]);
      MODE_BAYER_ROT: thr = bayer_thr(x[1:0] ^ f, y[1:0] ^ f);
`endif
      default:        thr = acc;
    endcase
  end

  // Stage p0 / p1: syncs follow the colour pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_p0 <= SYNC_IDLE;
      vs_p0 <= SYNC_IDLE;
      hs_p1 <= SYNC_IDLE;
      vs_p1 <= SYNC_IDLE;
    end else begin
      hs_p0 <= hsync;
      vs_p0 <= vsync;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
    end
  end

  assign hsync_out = hs_p1;
  assign vsync_out = vs_p1;

  vga_dither_chan #(.IN_W(IN_W), .OUT_W(OUT_W), .DEP_W(DEP_W)) u_red (
    .clk(clk), .rst_n(rst_n), .c(r), .depth(dep_s), .thr(thr), .q(red)
  );

  vga_dither_chan #(.IN_W(IN_W), .OUT_W(OUT_W), .DEP_W(DEP_W)) u_green (
    .clk(clk), .rst_n(rst_n), .c(g), .depth(dep_s), .thr(thr), .q(green)
  );

  vga_dither_chan #(.IN_W(IN_W), .OUT_W(OUT_W), .DEP_W(DEP_W)) u_blue (
    .clk(clk), .rst_n(rst_n), .c(b), .depth(dep_s), .thr(thr), .q(blue)
  );

endmodule

// File: tb/tb_vga_dither_quantizer.sv
// Scoreboard bench for vga_dither_quantizer (IN_W=8, OUT_W=2, STEP=149):
// a behavioural model predicts each pixel, the result is compared two clocks later.
module tb_vga_dither_quantizer;

`ifdef VGA_DITHER_BAYER_EN
  localparam bit BAYER_ON = 1'b1;
`else
  localparam bit BAYER_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       hsync = 1'b1, vsync = 1'b1;
  logic [2:0] depth = 3'd7;
  logic [1:0] mode = 2'd0;
  logic [1:0] red, green, blue;
  logic       hsync_out, vsync_out;

  vga_dither_quantizer #(.IN_W(8), .OUT_W(2), .STEP(149)) dut (
    .clk(clk), .rst_n(rst_n), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .depth(depth), .mode(mode),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    int         want;
    bit         cnt;
  } ent_t;

  ent_t sb[$];
  int errors = 0, checks = 0;
  int ones = 0, zeros = 0, run = 0, last_run = 0;

  int BT[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int m_dep, m_mode, m_x, m_y, m_f, m_acc;
  bit m_hp, m_vp;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_dep = 7; m_mode = 0; m_x = 0; m_y = 0; m_f = 0; m_acc = 0;
    m_hp = 1'b1; m_vp = 1'b1;
  endfunction

  function automatic int m_expand(input int c, input int dep);
    int k = (dep > 7) ? 8 : dep + 1;
    int kept = c >> (8 - k);
    logic [127:0] lng = '0;
    for (int i = 0; i < 8; i++) lng = (lng << k) | 128'(kept);
    return int'((lng >> (8 * k - 8)) & 128'hFF);
  endfunction

  function automatic int m_thr();
    int xi = m_x & 3, yi = m_y & 3;
    if (m_mode == 0) return 128;
    if (m_mode == 1 || !BAYER_ON) return m_acc;
    if (m_mode == 3) begin
      xi = xi ^ m_f;
      yi = yi ^ m_f;
    end
    return BT[yi][xi] * 16 + 8;
  endfunction

  function automatic int m_quant(input int c, input int thr);
    int v = (m_expand(c, m_dep) * 3 + thr) >> 8;
    return (v > 3) ? 3 : v;
  endfunction

  function automatic void m_step(input bit hs, input bit vs, input int dp, input int md);
    if (!vs) begin
      m_dep = dp;
      m_mode = md;
    end
    m_acc = vs ? (m_acc + 149) % 256 : 0;
    m_x = hs ? (m_x + 1) % 2048 : 0;
    if (!vs) m_y = 0;
    else if (m_hp && !hs) m_y = m_y + 1;
    if (m_vp && !vs) m_f = (m_f + 1) % 4;
    m_hp = hs;
    m_vp = vs;
  endfunction

  task automatic observe();
    ent_t e;
    if (!hsync_out) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk("pix", int'({red, green, blue, hsync_out, vsync_out}), int'(e.v));
      if (e.want >= 0) chk("red", int'(red), e.want);
      if (e.cnt) begin
        if (red == 2'd1) ones++;
        else if (red == 2'd0) zeros++;
      end
    end
  endtask

  task automatic pix(input int rr, input int gg, input int bb, input bit hs, input bit vs,
                     input int dp, input int md, input int want = -1, input bit cnt = 1'b0);
    ent_t e;
    int th;
    rst_n = 1'b1;
    r = 8'(rr); g = 8'(gg); b = 8'(bb);
    hsync = hs; vsync = vs; depth = 3'(dp); mode = 2'(md);
    th = m_thr();
    e.v = {2'(m_quant(rr, th)), 2'(m_quant(gg, th)), 2'(m_quant(bb, th)), hs, vs};
    e.want = want;
    e.cnt = cnt;
    sb.push_back(e);
    m_step(hs, vs, dp, md);
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  task automatic reset_clk();
    ent_t e;
    rst_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    sb.delete();
    e.v = 8'h03;
    e.want = 0;
    e.cnt = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  initial begin
    reset_clk();
    reset_clk();
    chk("rst_x", int'(dut.x), 0);
    chk("rst_y", int'(dut.y), 0);
    chk("rst_acc", int'(dut.acc), 0);
    chk("rst_dep", int'(dut.dep_s), 7);
    chk("rst_mode", int'(dut.mode_s), 0);

    // Round mode, full depth
    pix(0, 0, 0, 1, 0, 7, 0);
    pix(8'h80, 8'h80, 8'h80, 1, 1, 7, 0, 2);
    pix(8'hFF, 8'h40, 8'hC0, 1, 1, 7, 0, 3);
    pix(8'h00, 8'hAA, 8'h55, 1, 1, 7, 0, 0);
    for (int i = 0; i < 6; i++) pix($urandom_range(255), $urandom_range(255), $urandom_range(255), 1, 1, 7, 0);

    // Depth 0: only the MSB survives, every mode
    for (int md = 0; md < 4; md++) begin
      pix(0, 0, 0, 1, 0, 0, md);
      for (int i = 0; i < 6; i++) begin
        pix(8'h80, 8'h80, 8'h80, 1, 1, 0, md, (md == 0 || (BAYER_ON && md >= 2)) ? 3 : -1);
        pix(8'h7F, 8'h7F, 8'h7F, 1, 1, 0, md, 0);
      end
    end

    // Temporal mode over 256 clocks
    pix(8'h55, 8'h55, 8'h55, 1, 0, 7, 1);
    chk("acc_clr", int'(dut.acc), 0);
    ones = 0;
    zeros = 0;
    for (int i = 0; i < 256; i++) pix(8'h55, 8'h55, 8'h55, 1, 1, 7, 1, -1, 1'b1);
    pix(0, 0, 0, 1, 1, 7, 1);
    pix(0, 0, 0, 1, 1, 7, 1);
    chk("m1_ones", ones, 255);
    chk("m1_zeros", zeros, 1);

    // Ordered dither over a 4x4 block, then the rotating variant
    for (int md = 2; md < 4; md++) begin
      pix(8'h40, 8'h40, 8'h40, 0, 0, 7, md);
      for (int yy = 0; yy < 4; yy++) begin
        for (int xx = 0; xx < 4; xx++)
          pix(8'h40, 8'h40, 8'h40, 1, 1, 7, md,
              (BAYER_ON && md == 2) ? ((BT[yy][xx] >= 4) ? 1 : 0) : -1);
        pix(8'h40, 8'h40, 8'h40, 0, 1, 7, md);
      end
    end

    // Depth change mid-frame is ignored until vsync
    pix(8'h80, 0, 0, 1, 0, 7, 0);
    for (int i = 0; i < 3; i++) pix(8'h80, 8'h80, 8'h80, 1, 1, 0, 0, 2);
    pix(8'h80, 8'h80, 8'h80, 1, 0, 0, 0, 2);
    pix(8'h80, 8'h80, 8'h80, 1, 1, 0, 0, 3);

    // Hsync pulse width through the pipeline
    run = 0;
    last_run = 0;
    for (int i = 0; i < 96; i++) pix(8'h33, 8'h66, 8'h99, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) pix(8'h33, 8'h66, 8'h99, 1, 1, 0, 0);
    chk("hs_width", last_run, 96);

    // Reset in the middle of a line
    for (int i = 0; i < 10; i++) pix(8'hF0, 8'h0F, 8'h80, 1, 1, 0, 0);
    reset_clk();
    chk("mid_rst_x", int'(dut.x), 0);
    for (int i = 0; i < 4; i++) pix(8'hF0, 8'h0F, 8'h80, 1, 1, 7, 0);
    chk("x_restart", int'(dut.x), 4);

    // Mixed traffic
    for (int i = 0; i < 400; i++)
      pix($urandom_range(255), $urandom_range(255), $urandom_range(255),
          !((i % 37) < 3), !((i % 97) < 2), $urandom_range(7), $urandom_range(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
